// File: rtl/of_ctrl_pkg.sv
// Shared definitions for the OF-stage hazard scheduler: control-bus bit
// positions, instruction field positions and the scheduler state encoding.
package of_ctrl_pkg;

    // Control-bus bit indices
    localparam int WB_BIT    = 6;
    localparam int CALL_BIT  = 8;
    localparam int STORE_BIT = 0;
    localparam int RET_BIT   = 4;
    localparam int IMM_BIT   = 5;

    // Bus widths
    localparam int IR_W  = 32;
    localparam int CB_W  = 22;
    localparam int REG_W = 4;

    // Return-address register, implicit destination of calls and source of returns
    localparam logic [REG_W-1:0] RA_IDX = 4'hF;

    // Instruction register field positions (low bit of each 4-bit field)
    localparam int RD_LO  = 22;
    localparam int RS1_LO = 18;
    localparam int RS2_LO = 14;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_INTERLOCK = 2'd1,
        ST_FLUSH     = 2'd2
    } of_state_e;

    // Extract a 4-bit register index starting at bit position lo
    function automatic logic [REG_W-1:0] ir_field(input logic [IR_W-1:0] ir, input int lo);
        return ir[lo +: REG_W];
    endfunction

endpackage

// File: rtl/of_scoreboard_pipe.sv
// Three-entry destination scoreboard mirroring the EX, MA and RW latches.
// Reports, per OF source operand, which in-flight entries hold it as a dest.
module of_scoreboard_pipe
    import of_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             new_valid,
    input  logic [REG_W-1:0] new_dest,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    output logic [2:0]       sb_valid,
    output logic [2:0]       src1_hit,
    output logic [2:0]       src2_hit
);

    logic             ex_valid_r, ma_valid_r, rw_valid_r;
    logic [REG_W-1:0] ex_dest_r, ma_dest_r, rw_dest_r;

    // Shift the scoreboard one stage per unfrozen cycle; a frozen pipe holds
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_r <= 1'b0;
            ma_valid_r <= 1'b0;
            rw_valid_r <= 1'b0;
            ex_dest_r  <= 4'h0;
            ma_dest_r  <= 4'h0;
            rw_dest_r  <= 4'h0;
        end else if (advance) begin
            ex_valid_r <= new_valid;
            ex_dest_r  <= new_dest;
            ma_valid_r <= ex_valid_r;
            ma_dest_r  <= ex_dest_r;
            rw_valid_r <= ma_valid_r;
            rw_dest_r  <= ma_dest_r;
        end else begin
            ex_valid_r <= ex_valid_r;
            ma_valid_r <= ma_valid_r;
            rw_valid_r <= rw_valid_r;
            ex_dest_r  <= ex_dest_r;
            ma_dest_r  <= ma_dest_r;
            rw_dest_r  <= rw_dest_r;
        end
    end

    // Per-source match vectors ordered {RW, MA, EX}
    always_comb begin
        sb_valid = {rw_valid_r, ma_valid_r, ex_valid_r};
        src1_hit = {rw_valid_r & (rw_dest_r == src1),
                    ma_valid_r & (ma_dest_r == src1),
                    ex_valid_r & (ex_dest_r == src1)};
        src2_hit = {rw_valid_r & (rw_dest_r == src2),
                    ma_valid_r & (ma_dest_r == src2),
                    ex_valid_r & (ex_dest_r == src2)};
    end

endmodule

// File: rtl/of_hazard_scheduler.sv
// OF-stage scheduler: decides advance / interlock / flush for the OF
// instruction, drives RW->OF forwarding selects and keeps statistics.
module of_hazard_scheduler
    import of_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             of_valid,
    input  logic [IR_W-1:0]  of_IR,
    input  logic [CB_W-1:0]  of_controlBus,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             stall_OF,
    output logic             bubble_EX,
    output logic             is_RW_OF_conflict_src1,
    output logic             is_RW_OF_conflict_src2,
    output logic [2:0]       sb_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    of_state_e        state_r, state_next_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic [REG_W-1:0] src1_s, src2_s, dest_s;
    logic             src2_used_s, writes_s, hazard_s;
    logic             advance_of_s, inc_stall_s, inc_flush_s;
    logic [2:0]       src1_hit_s, src2_hit_s;
    logic             unused_ir_s;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    assign unused_ir_s = ^{of_IR[31:26], of_IR[13:0]};

    // Operand decode: which registers the OF instruction reads and writes
    always_comb begin
        src1_s      = of_controlBus[RET_BIT]   ? RA_IDX : ir_field(of_IR, RS1_LO);
        src2_s      = of_controlBus[STORE_BIT] ? ir_field(of_IR, RD_LO) : ir_field(of_IR, RS2_LO);
        src2_used_s = ~of_controlBus[IMM_BIT] | of_controlBus[STORE_BIT];
        dest_s      = of_controlBus[CALL_BIT]  ? RA_IDX : ir_field(of_IR, RD_LO);
        writes_s    = of_valid & (of_controlBus[WB_BIT] | of_controlBus[CALL_BIT]);
    end

    of_scoreboard_pipe u_sb (
        .clk       (clk),
        .reset     (reset),
        .advance   (~mem_busy),
        .new_valid (advance_of_s & writes_s),
        .new_dest  (dest_s),
        .src1      (src1_s),
        .src2      (src2_s),
        .sb_valid  (sb_valid),
        .src1_hit  (src1_hit_s),
        .src2_hit  (src2_hit_s)
    );

    // Hazard on EX/MA producers; a lone RW match is covered by forwarding
    always_comb begin
        hazard_s = of_valid & ((|src1_hit_s[1:0]) | (src2_used_s & (|src2_hit_s[1:0])));
        is_RW_OF_conflict_src1 = of_valid & src1_hit_s[2];
        is_RW_OF_conflict_src2 = of_valid & src2_used_s & src2_hit_s[2];
    end

    // Next-state and latch controls: freeze > flush > interlock > advance
    always_comb begin
        state_next_s = state_r;
        stall_OF     = 1'b0;
        bubble_EX    = 1'b0;
        advance_of_s = 1'b0;
        inc_stall_s  = 1'b0;
        inc_flush_s  = 1'b0;
        if (mem_busy) begin
            stall_OF     = 1'b1;
        end else if (branch_taken || (state_r == ST_FLUSH)) begin
            bubble_EX    = 1'b1;
            inc_flush_s  = of_valid;
            state_next_s = branch_taken ? ST_FLUSH : ST_RUN;
        end else if (hazard_s) begin
            stall_OF     = 1'b1;
            bubble_EX    = 1'b1;
            inc_stall_s  = 1'b1;
            state_next_s = ST_INTERLOCK;
        end else begin
            advance_of_s = 1'b1;
            state_next_s = ST_RUN;
        end
    end

    // State register and statistics counters; a frozen pipe holds them
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (!mem_busy) begin
            state_r     <= state_next_s;
            stall_cnt_r <= sat_inc(stall_cnt_r, inc_stall_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, inc_flush_s);
        end else begin
            state_r     <= state_r;
            stall_cnt_r <= stall_cnt_r;
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign state       = state_r;
    assign stall_count = stall_cnt_r;
    assign flush_count = flush_cnt_r;

endmodule
